// File: rtl/ysyx_25020047_exec_seq.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_exec_seq
//
// Multi-cycle execution sequencer for the NPC core. Each instruction goes
// through FETCH -> DECODE -> EXEC -> (MEM) -> WB. This block owns every
// architectural write strobe. The writeback mux elsewhere builds wdata/dnpc
// combinationally; this block only decides the cycle in which they commit.
//
// Ports:
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   ifu_req       : fetch request, high in FETCH
//   ifu_valid     : fetched instruction valid (sampled in FETCH only)
//   inst_wen      : instruction-register latch strobe (FETCH && ifu_valid)
//   inst_type     : one-hot decoded type, stable from DECODE through WB
//   ebreak        : decoded ebreak, sampled in EXEC
//   lsu_req       : memory request, high in MEM
//   lsu_wen       : 1 = store, 0 = load (meaningful while lsu_req = 1)
//   lsu_valid     : memory access complete (sampled in MEM only)
//   rf_wen        : register-file write strobe (WB, unless store/branch)
//   pc_wen        : PC update strobe (WB)
//   halted        : sticky halt after ebreak or trap
//   trap          : sticky trap (illegal type or memory timeout)
//   cycle_cnt     : cycles since reset; frozen while halted
//   instret_cnt   : number of pc_wen pulses since reset
// ---------------------------------------------------------------------------
module ysyx_25020047_exec_seq #(
    parameter logic [63:0] LOAD_MASK   = 64'hE0_0000_0060,
    parameter logic [63:0] STORE_MASK  = 64'h0000_0020_0180,
    parameter logic [63:0] BRANCH_MASK = 64'h0000_0000_F000_C000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_valid,
    output logic        inst_wen,
    input  logic [63:0] inst_type,
    input  logic        ebreak,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_valid,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halted,
    output logic        trap,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // The wait counter holds the number of MEM cycles already spent without
    // lsu_valid, so the last permitted cycle is MEM_TIMEOUT-1.
    localparam logic [8:0] WAIT_LAST = 9'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       trap_set;
    logic [8:0] wait_cnt;
    logic       mem_timeout;
    logic       type_onehot;
    logic       type_mem;
    logic       is_store;
    logic       no_rd;

    assign type_onehot = (inst_type != 64'd0) &&
                         ((inst_type & (inst_type - 64'd1)) == 64'd0);
    assign type_mem    = (inst_type & (LOAD_MASK | STORE_MASK)) != 64'd0;
    assign mem_timeout = (wait_cnt == WAIT_LAST);

    // Next-state logic
    always_comb begin
        state_next = state;
        trap_set   = 1'b0;
        case (state)
            S_FETCH: begin
                if (ifu_valid) state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (ebreak) begin
                    state_next = S_HALT;
                end else if (!type_onehot) begin
                    state_next = S_HALT;
                    trap_set   = 1'b1;
                end else if (type_mem) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                // A completion in the timeout cycle still counts.
                if (lsu_valid) begin
                    state_next = S_WB;
                end else if (mem_timeout) begin
                    state_next = S_HALT;
                    trap_set   = 1'b1;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Control state, sticky status and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            trap        <= 1'b0;
            wait_cnt    <= 9'd0;
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            state <= state_next;
            if (trap_set) trap <= 1'b1;
            // Cleared whenever outside MEM, so every MEM entry starts at zero.
            if (state == S_MEM) wait_cnt <= wait_cnt + 9'd1;
            else                wait_cnt <= 9'd0;
            if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (state == S_WB)   instret_cnt <= instret_cnt + 32'd1;
        end
    end

    // Type attributes captured in EXEC so the MEM/WB strobes depend on
    // registered values only.
    always_ff @(posedge clk) begin
        if (state == S_EXEC) begin
            is_store <= (inst_type & STORE_MASK) != 64'd0;
            no_rd    <= (inst_type & (STORE_MASK | BRANCH_MASK)) != 64'd0;
        end
    end

    // Moore outputs; inst_wen is the single input-to-output path.
    assign ifu_req  = (state == S_FETCH);
    assign inst_wen = (state == S_FETCH) && ifu_valid;
    assign lsu_req  = (state == S_MEM);
    assign lsu_wen  = (state == S_MEM) && is_store;
    assign pc_wen   = (state == S_WB);
    assign rf_wen   = (state == S_WB) && !no_rd;
    assign halted   = (state == S_HALT);

endmodule

// File: doc/ysyx_25020047_exec_seq.md
# ysyx_25020047_exec_seq

Multi-cycle execution sequencer for the NPC core. Steps each instruction through fetch, decode, execute, memory and writeback, and owns all architectural write strobes: instruction latch, LSU request, register-file write and PC update. The writeback mux combinationally produces `wdata`/`dnpc`; this block decides the cycle in which they are committed. It also keeps cycle and retired-instruction counters and a sticky halt/trap status.

## Interface
Parameters:
- `LOAD_MASK`, default 64'hE0_0000_0060: `inst_type` bits for lb/lh/lw/lbu/lhu.
- `STORE_MASK`, default 64'h0000_0020_0180: `inst_type` bits for sb/sh/sw.
- `BRANCH_MASK`, default 64'h0000_0000_F000_C000: bits for conditional branches (no rd write).
- `MEM_TIMEOUT`, default 255: maximum cycles to wait for `lsu_valid`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ifu_req` out 1: fetch request to the IFU.
- `ifu_valid` in 1: fetched instruction valid; sampled while `ifu_req`=1.
- `inst_wen` out 1: one-cycle strobe latching the instruction register.
- `inst_type` in 64: one-hot decoded type; stable from DECODE through WB.
- `ebreak` in 1: decoded ebreak; sampled in EXEC.
- `lsu_req` out 1: memory access request.
- `lsu_wen` out 1: 1 = store, 0 = load; valid while `lsu_req`=1.
- `lsu_valid` in 1: memory access complete.
- `rf_wen` out 1: register-file write strobe; the register file samples `wdata`.
- `pc_wen` out 1: PC update strobe; the PC register samples `dnpc`.
- `halted` out 1: sticky; 1 after ebreak or trap.
- `trap` out 1: sticky; 1 for an illegal instruction or memory timeout.
- `cycle_cnt` out 32: cycles since reset; stops when halted.
- `instret_cnt` out 32: number of `pc_wen` pulses since reset.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - `ifu_req`=1.
  - On `ifu_valid`=1, pulse `inst_wen` in that cycle and go to DECODE.
  - Otherwise stay in FETCH indefinitely.
- DECODE: one cycle; go to EXEC.
- EXEC: one cycle; transitions by priority:
  1. `ebreak`=1 → HALT, `halted`=1, `trap`=0. No writeback, no PC update.
  2. `inst_type`==0 or not one-hot → HALT with `halted`=1 and `trap`=1.
  3. `inst_type` & (`LOAD_MASK`|`STORE_MASK`) ≠ 0 → MEM.
  4. Otherwise → WB.
- MEM:
  - `lsu_req`=1; `lsu_wen`=1 if the type is in `STORE_MASK`.
  - On `lsu_valid` → WB.
  - A 9-bit wait counter is cleared on MEM entry. If it reaches `MEM_TIMEOUT` without `lsu_valid` → HALT with `trap`=1.
  - `lsu_valid` and timeout in the same cycle: `lsu_valid` wins.
- WB: one cycle, then → FETCH.
  - `pc_wen`=1.
  - `rf_wen`=1 unless the type is in `STORE_MASK` or `BRANCH_MASK`.
  - `instret_cnt` increments.
- HALT:
  - Absorbing; all strobes 0; counters frozen.
  - Exit only via `rst`.
- Counters:
  - 32-bit, wrap modulo 2^32 with no flag.
  - `cycle_cnt` increments every cycle in any state except HALT.
- Only one of `inst_wen`, `lsu_req`, `rf_wen`/`pc_wen` is active in any cycle. Inputs arriving outside their sampling state are ignored (e.g. `lsu_valid` during FETCH).

## Timing
- Reset (async assert, sync release):
  - state=FETCH; `halted`=0, `trap`=0, `cycle_cnt`=0, `instret_cnt`=0.
  - `inst_wen`, `lsu_req`, `lsu_wen`, `rf_wen`, `pc_wen` = 0.
  - `ifu_req`=1 from the first cycle after release.
- Reset asserted mid-instruction aborts it immediately: no strobe is issued and counters clear.
- All outputs are decoded from registered state only (Moore); no combinational input-to-output paths except `inst_wen`=`ifu_valid` in FETCH.
- Latency per instruction with zero-wait IFU and LSU:
  - ALU, branch and jump: FETCH1 + DECODE1 + EXEC1 + WB1 = 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle on `ifu_valid` or `lsu_valid` adds one cycle.
- `rf_wen` and `pc_wen` are coincident single-cycle pulses. PC and register file update on the same rising edge that leaves WB.

## Test plan
- Reset, then addi (`inst_type`=64'h1), `ifu_valid`=1 in the first FETCH cycle:
  - `inst_wen` in cycle 0; `rf_wen`=`pc_wen`=1 in cycle 3.
  - `instret_cnt`=1, `cycle_cnt`=4.
- lw (64'h20) with `lsu_valid` delayed 3 cycles:
  - `lsu_req` high for 4 cycles with `lsu_wen`=0.
  - WB follows with `rf_wen`=1; instruction total 8 cycles.
- sw (64'h80) and then bne (64'h8000):
  - Both give `pc_wen`=1, `rf_wen`=0.
  - sw holds `lsu_wen`=1 during MEM.
- Illegal `inst_type`=64'h3 → `trap`=`halted`=1 after EXEC; no further strobes; `cycle_cnt` frozen.
- `ebreak`=1 at EXEC → `halted`=1, `trap`=0, `instret_cnt` unchanged.
- Load with `lsu_valid` never asserted → trap after 255 MEM cycles.
- `rst` pulsed during MEM → `lsu_req` drops immediately; restart in FETCH with counters at 0.
